// File: rtl/wishbone_timeout_guard_if.sv
// Point-to-point Wishbone (pipelined, single outstanding) bus bundle.
// Handshake: a request is accepted on a clock edge where cyc & stb & !stall; the
// cycle completes on the edge where ack or err is high while cyc is held.
interface wishbone_timeout_guard_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [23:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, stall, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, stall, err
  );
endinterface

// File: rtl/wishbone_timeout_guard.sv
// Wishbone guard between the shared-slave mux and one peripheral: passes single
// transactions through, aborts with a one-cycle error when the slave stops answering.
module wishbone_timeout_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNTER_WIDTH  = 8
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  wishbone_timeout_guard_if.slave         master_wb,
  wishbone_timeout_guard_if.master        slave_wb,
  output logic [1:0]                      probe_state,
  output logic [7:0]                      probe_timeoutCount,
  output logic [23:0]                     probe_lastTimeoutAdr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ABORT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // The count equals the cycle index since the first request cycle, so a count
  // of TIMEOUT_CYCLES-1 without a response means the error lands in cycle TIMEOUT_CYCLES.
  localparam logic [COUNTER_WIDTH-1:0] LIMIT_M1 = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   count_q, count_d;
  logic [7:0]                 to_cnt_q, to_cnt_d;
  logic [23:0]                last_adr_q, last_adr_d;

  logic req;
  logic slv_done;
  logic at_limit;
  logic timeout_hit;
  logic [COUNTER_WIDTH-1:0] count_inc;

  assign req       = master_wb.cyc & master_wb.stb;
  assign slv_done  = slave_wb.ack | slave_wb.err;
  assign at_limit  = (count_q >= LIMIT_M1);
  assign count_inc = at_limit ? count_q : (count_q + CNT_ONE);

  // Data and qualifiers are never gated; only cyc/stb and the responses are.
  assign slave_wb.we     = master_wb.we;
  assign slave_wb.sel    = master_wb.sel;
  assign slave_wb.adr    = master_wb.adr;
  assign slave_wb.dat_w  = master_wb.dat_w;
  assign master_wb.dat_r = slave_wb.dat_r;

  always_comb begin
    state_d     = state_q;
    count_d     = '0;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !slv_done && at_limit) begin
          state_d     = ST_ABORT;
          timeout_hit = 1'b1;
        end else if (req && !slave_wb.stall && !slv_done) begin
          state_d = ST_WAIT;
          count_d = CNT_ONE;
        end else if (req && slave_wb.stall) begin
          count_d = count_inc;
        end
      end
      ST_WAIT: begin
        if (slv_done || !master_wb.cyc) begin
          state_d = ST_IDLE;
        end else if (at_limit) begin
          state_d     = ST_ABORT;
          timeout_hit = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
      ST_ABORT: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!master_wb.cyc) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    last_adr_d = last_adr_q;
    to_cnt_d   = to_cnt_q;
    if (timeout_hit) begin
      last_adr_d = master_wb.adr;
      if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  // Bus-facing handshake outputs; held in the safe state while reset is high.
  always_comb begin
    slave_wb.cyc    = 1'b0;
    slave_wb.stb    = 1'b0;
    master_wb.stall = 1'b1;
    master_wb.ack   = 1'b0;
    master_wb.err   = 1'b0;
    if (!wb_rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          slave_wb.cyc    = master_wb.cyc;
          slave_wb.stb    = master_wb.stb;
          master_wb.stall = slave_wb.stall;
          master_wb.ack   = slave_wb.ack & master_wb.cyc;
          master_wb.err   = slave_wb.err & master_wb.cyc;
        end
        ST_WAIT: begin
          slave_wb.cyc  = master_wb.cyc;
          master_wb.ack = slave_wb.ack & master_wb.cyc;
          master_wb.err = slave_wb.err & master_wb.cyc;
        end
        ST_ABORT: begin
          master_wb.err = 1'b1;
        end
        ST_RECOVER: begin
          master_wb.err = 1'b0;
        end
        default: begin
          master_wb.err = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      to_cnt_q   <= '0;
      last_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      to_cnt_q   <= to_cnt_d;
      last_adr_q <= last_adr_d;
    end
  end

  assign probe_state          = state_q;
  assign probe_timeoutCount   = to_cnt_q;
  assign probe_lastTimeoutAdr = last_adr_q;

endmodule

// File: tb/tb_wishbone_timeout_guard.sv
// Directed bench for wishbone_timeout_guard with TIMEOUT_CYCLES=8; responses on the
// master side are checked by a monitor against an expected queue.
module tb_wishbone_timeout_guard;

  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  probe_state;
  logic [7:0]  probe_cnt;
  logic [23:0] probe_adr;

  wishbone_timeout_guard_if m_if();
  wishbone_timeout_guard_if s_if();

  wishbone_timeout_guard #(
    .TIMEOUT_CYCLES (T),
    .COUNTER_WIDTH  (8)
  ) dut (
    .wb_clk_i             (clk),
    .wb_rst_i             (rst),
    .master_wb            (m_if),
    .slave_wb             (s_if),
    .probe_state          (probe_state),
    .probe_timeoutCount   (probe_cnt),
    .probe_lastTimeoutAdr (probe_adr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // entry = {ack, err, data}
  logic [33:0] exp_q[$];
  logic [33:0] mon_got;
  logic [33:0] mon_exp;
  int n_cmp = 0;
  int n_mis = 0;
  int exp_cnt = 0;
  logic [23:0] exp_adr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (m_if.ack || m_if.err)) begin
      mon_got = {m_if.ack, m_if.err, m_if.dat_r};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_response: got ack=%0b err=%0b data=%08h, required none (t=%0t)",
                 m_if.ack, m_if.err, m_if.dat_r, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("response", mon_got, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master();
    m_if.cyc   = 1'b0;
    m_if.stb   = 1'b0;
    m_if.we    = 1'b0;
    m_if.sel   = 4'h0;
    m_if.adr   = 24'h0;
    m_if.dat_w = 32'h0;
  endtask

  task automatic drive_req(input logic [23:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat);
    m_if.cyc   = 1'b1;
    m_if.stb   = 1'b1;
    m_if.we    = we;
    m_if.sel   = sel;
    m_if.adr   = adr;
    m_if.dat_w = wdat;
  endtask

  // Normal transaction: stall_n stall cycles, accept, ack ack_after cycles later.
  task automatic txn(input logic [23:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] wdat, input int stall_n, input int ack_after,
                     input logic [31:0] rdat);
    for (int c = 0; c < stall_n; c++) begin
      next_cycle();
      drive_req(adr, we, sel, wdat);
      s_if.stall = 1'b1;
      @(negedge clk);
      chk("stall_mirror", m_if.stall, 1'b1);
      chk("stall_state", probe_state, 2'd0);
    end
    next_cycle();
    drive_req(adr, we, sel, wdat);
    s_if.stall = 1'b0;
    @(negedge clk);
    chk("accept_stall", m_if.stall, 1'b0);
    chk("accept_s_stb", s_if.stb, 1'b1);
    chk("accept_s_adr", s_if.adr, adr);
    chk("accept_s_we", s_if.we, we);
    chk("accept_s_sel", s_if.sel, sel);
    chk("accept_s_dat", s_if.dat_w, wdat);
    for (int c = 1; c <= ack_after; c++) begin
      next_cycle();
      m_if.stb = 1'b0;
      if (c == ack_after) begin
        s_if.ack   = 1'b1;
        s_if.dat_r = rdat;
        exp_q.push_back({2'b10, rdat});
      end
      @(negedge clk);
      chk("wait_stall", m_if.stall, 1'b1);
      chk("wait_s_stb", s_if.stb, 1'b0);
      chk("wait_s_cyc", s_if.cyc, 1'b1);
    end
    next_cycle();
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'h0;
    idle_master();
    @(negedge clk);
    chk("txn_end_state", probe_state, 2'd0);
  endtask

  // Forced timeout, either in the stall phase or waiting for ack; error in cycle T.
  task automatic timeout_once(input logic [23:0] adr, input logic stall_phase);
    next_cycle();
    drive_req(adr, 1'b0, 4'hF, 32'h0);
    s_if.stall = stall_phase;
    exp_q.push_back({2'b01, 32'h0});
    for (int c = 1; c < T; c++) begin
      next_cycle();
      if (!stall_phase) m_if.stb = 1'b0;
    end
    next_cycle();
    @(negedge clk);
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    exp_adr = adr;
    chk("to_state_abort", probe_state, 2'd2);
    chk("to_s_cyc", s_if.cyc, 1'b0);
    chk("to_count", probe_cnt, exp_cnt[7:0]);
    chk("to_last_adr", probe_adr, exp_adr);
    next_cycle();
    idle_master();
    s_if.stall = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("to_back_idle", probe_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_master();
    m_if.cyc   = 1'b1;
    m_if.stb   = 1'b1;
    s_if.ack   = 1'b1;
    s_if.err   = 1'b0;
    s_if.stall = 1'b0;
    s_if.dat_r = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cyc", s_if.cyc, 1'b0);
    chk("rst_s_stb", s_if.stb, 1'b0);
    chk("rst_m_ack", m_if.ack, 1'b0);
    chk("rst_m_err", m_if.err, 1'b0);
    chk("rst_m_stall", m_if.stall, 1'b1);
    next_cycle();
    rst = 1'b0;
    idle_master();
    s_if.ack = 1'b0;
    @(negedge clk);
    chk("rst_state", probe_state, 2'd0);
    chk("rst_count", probe_cnt, 8'd0);
    chk("rst_last_adr", probe_adr, 24'd0);

    // basic read, ack 2 cycles after accept
    txn(24'h000010, 1'b0, 4'hF, 32'h0, 0, 2, 32'hDEADBEEF);
    chk("t1_count", probe_cnt, 8'd0);

    // write with 3 stall cycles, ack the cycle after accept
    txn(24'h000200, 1'b1, 4'h3, 32'hA5A55A5A, 3, 1, 32'h12345678);

    // ack-phase timeout, late ack dropped
    next_cycle();
    drive_req(24'h00ABCD, 1'b0, 4'hF, 32'h0);
    exp_q.push_back({2'b01, 32'h0});
    for (int c = 1; c < T; c++) begin
      next_cycle();
      m_if.stb = 1'b0;
      @(negedge clk);
      chk("t3_wait_s_cyc", s_if.cyc, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    exp_cnt = 1;
    exp_adr = 24'h00ABCD;
    chk("t3_state_abort", probe_state, 2'd2);
    chk("t3_s_cyc_low", s_if.cyc, 1'b0);
    chk("t3_abort_stall", m_if.stall, 1'b1);
    chk("t3_last_adr", probe_adr, exp_adr);
    chk("t3_count", probe_cnt, 8'd1);
    next_cycle();
    @(negedge clk);
    chk("t3_recover", probe_state, 2'd3);
    chk("t3_recover_s_cyc", s_if.cyc, 1'b0);
    next_cycle();
    s_if.ack   = 1'b1;
    s_if.dat_r = 32'h55555555;
    @(negedge clk);
    chk("t3_late_ack_dropped", m_if.ack, 1'b0);
    next_cycle();
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'h0;
    idle_master();
    @(negedge clk);
    chk("t3_still_recover", probe_state, 2'd3);
    next_cycle();
    @(negedge clk);
    chk("t3_idle", probe_state, 2'd0);

    // ack in cycle T-1 wins over the limit
    txn(24'h000300, 1'b0, 4'hF, 32'h0, 0, T - 1, 32'hCAFEF00D);
    chk("t4a_count", probe_cnt, 8'd1);

    // master abandons in WAIT at cycle 4
    next_cycle();
    drive_req(24'h000444, 1'b0, 4'hF, 32'h0);
    for (int c = 1; c < 4; c++) begin
      next_cycle();
      m_if.stb = 1'b0;
    end
    next_cycle();
    idle_master();
    @(negedge clk);
    chk("t4b_s_cyc_follow", s_if.cyc, 1'b0);
    for (int c = 5; c < 5 + T; c++) begin
      next_cycle();
      @(negedge clk);
      chk("t4b_idle", probe_state, 2'd0);
      chk("t4b_no_err", m_if.err, 1'b0);
    end
    chk("t4b_count", probe_cnt, 8'd1);

    // stall-phase timeout
    timeout_once(24'h00F00D, 1'b1);

    // saturate the timeout counter
    for (int i = 0; i < 300; i++) begin
      timeout_once(24'h100000 + 24'(i * 7), 1'(i % 2));
    end
    chk("sat_count", probe_cnt, 8'd255);

    // reset during WAIT
    next_cycle();
    drive_req(24'h000777, 1'b0, 4'hF, 32'h0);
    for (int c = 1; c < 3; c++) begin
      next_cycle();
      m_if.stb = 1'b0;
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_cyc", s_if.cyc, 1'b0);
    chk("mid_rst_stall", m_if.stall, 1'b1);
    next_cycle();
    rst = 1'b0;
    idle_master();
    @(negedge clk);
    chk("post_rst_state", probe_state, 2'd0);
    chk("post_rst_count", probe_cnt, 8'd0);
    chk("post_rst_adr", probe_adr, 24'd0);
    txn(24'h000020, 1'b0, 4'hF, 32'h0, 1, 2, 32'h0BADF00D);
    chk("post_rst_txn_count", probe_cnt, 8'd0);

    repeat (3) next_cycle();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
